// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Generates the fetch PC, issues in-order word
//   requests to instruction memory, buffers returned words with their PC in a
//   small FIFO and presents one {instr, pc} per cycle to decode. Redirects from
//   execute flush the buffer and discard responses to requests already in flight.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_redirect, i_redirect_pc   taken branch/JALR pulse and its target
//   i_stall                     decode cannot accept this cycle
//   o_imem_req, o_imem_addr     fetch request and word address
//   i_imem_gnt                  request accepted this cycle
//   i_imem_rvalid, i_imem_rdata in-order response, one per grant, latency >= 1
//   o_valid, o_instr, o_pc      instruction presented to decode
//   o_pc_plus4                  o_pc + 4 (wraps)
//   o_fsm_drain                 debug: 1 while in DRAIN, 0 in FETCH
//
// Handshakes
//   Memory side: a request transfers on a cycle where o_imem_req && i_imem_gnt;
//   o_imem_addr is held until that happens. Responses are never back-pressured.
//   Decode side: an entry transfers on a cycle where o_valid && !i_stall;
//   o_instr/o_pc are held while o_valid && i_stall.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_stall,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [31:0]     i_imem_rdata,
   output logic            o_valid,
   output logic [31:0]     o_instr,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus4,
   output logic            o_fsm_drain
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [XLEN-1:0]   fetch_pc, fetch_pc_n;
   logic [XLEN-1:0]   resp_pc, resp_pc_n;
   logic [XLEN-1:0]   redir_aligned;
   logic [CW-1:0]     outstanding, outstanding_n;
   logic [CW-1:0]     discard, discard_n;
   logic [CW-1:0]     count, count_n;
   logic [PW-1:0]     wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic              req_q, req_n;
   logic              grant, pop, push;
   logic [31:0]       fifo_instr [FIFO_DEPTH];
   logic [XLEN-1:0]   fifo_pc    [FIFO_DEPTH];

   always_comb begin
      grant         = req_q & i_imem_gnt;
      pop           = (count != '0) & ~i_stall;
      // Responses only land in the FIFO once every stale one has been dropped.
      push          = i_imem_rvalid & ~i_redirect & (discard == '0);
      redir_aligned = i_redirect_pc & ~(XLEN'(3));
      outstanding_n = outstanding + CW'(grant) - CW'(i_imem_rvalid);

      fetch_pc_n = fetch_pc;
      resp_pc_n  = resp_pc;
      discard_n  = discard;
      count_n    = count;
      wr_ptr_n   = wr_ptr;
      rd_ptr_n   = rd_ptr;
      state_n    = state;

      if (i_redirect) begin
         // Everything still in flight after this cycle belongs to the old path,
         // including a request granted now; a same-cycle response is dropped.
         fetch_pc_n = redir_aligned;
         resp_pc_n  = redir_aligned;
         discard_n  = outstanding_n;
         count_n    = '0;
         wr_ptr_n   = '0;
         rd_ptr_n   = '0;
         state_n    = (outstanding_n != '0) ? S_DRAIN : S_FETCH;
      end else begin
         if (grant) begin
            fetch_pc_n = fetch_pc + XLEN'(4);
         end
         if (i_imem_rvalid && (discard != '0)) begin
            discard_n = discard - CW'(1);
         end
         if (push) begin
            resp_pc_n = resp_pc + XLEN'(4);
            wr_ptr_n  = wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr_n = rd_ptr + PW'(1);
         end
         count_n = count + CW'(push) - CW'(pop);
         if ((state == S_DRAIN) && (discard == '0)) begin
            state_n = S_FETCH;
         end
      end

      // Request is registered: evaluated on next-cycle occupancy so that it is
      // low during reset and every granted word is guaranteed a FIFO slot.
      req_n = (state_n == S_FETCH) &&
              (({1'b0, outstanding_n} + {1'b0, count_n}) < DEPTH_C);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_FETCH;
         fetch_pc    <= RESET_PC & ~(XLEN'(3));
         resp_pc     <= RESET_PC & ~(XLEN'(3));
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         req_q       <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else begin
         state       <= state_n;
         fetch_pc    <= fetch_pc_n;
         resp_pc     <= resp_pc_n;
         outstanding <= outstanding_n;
         discard     <= discard_n;
         count       <= count_n;
         wr_ptr      <= wr_ptr_n;
         rd_ptr      <= rd_ptr_n;
         req_q       <= req_n;
         if (push) begin
            fifo_instr[wr_ptr] <= i_imem_rdata;
            fifo_pc[wr_ptr]    <= resp_pc;
         end
      end
   end

   assign o_imem_req  = req_q;
   assign o_imem_addr = fetch_pc;
   assign o_valid     = (count != '0);
   assign o_instr     = fifo_instr[rd_ptr];
   assign o_pc        = fifo_pc[rd_ptr];
   assign o_pc_plus4  = fifo_pc[rd_ptr] + XLEN'(4);
   assign o_fsm_drain = (state == S_DRAIN);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int XLEN = 32;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   always #5 clk = ~clk;

   logic            i_redirect = 1'b0;
   logic [XLEN-1:0] i_redirect_pc = '0;
   logic            i_stall = 1'b0;
   logic            i_imem_gnt = 1'b0;
   logic            i_imem_rvalid = 1'b0;
   logic [31:0]     i_imem_rdata = '0;
   logic            o_imem_req;
   logic [XLEN-1:0] o_imem_addr;
   logic            o_valid;
   logic [31:0]     o_instr;
   logic [XLEN-1:0] o_pc;
   logic [XLEN-1:0] o_pc_plus4;
   logic            o_fsm_drain;

   fetch_unit dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_stall       (i_stall),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_valid       (o_valid),
      .o_instr       (o_instr),
      .o_pc          (o_pc),
      .o_pc_plus4    (o_pc_plus4),
      .o_fsm_drain   (o_fsm_drain)
   );

   // ---------------- models and scoreboard ----------------
   int              n_vec = 0;
   int              n_err = 0;
   int              cyc = 0;
   int              lat_min = 1;
   int              lat_max = 1;
   logic [31:0]     mem_addr_q[$];   // memory: pending responses, in order
   int              mem_due_q[$];
   logic [XLEN-1:0] exp_q[$];        // next PC decode must see
   logic [XLEN-1:0] exp_fetch;       // next address the fetcher must request
   logic            s_req, s_valid, s_drain;
   logic [31:0]     s_addr, s_pc, s_instr, s_plus4;
   bit              chk_valid_low = 0;
   bit              redir_fired = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
   endfunction

   // One clock: sample at the falling edge, score, then drive the next inputs.
   task automatic step(input bit redir, input logic [31:0] tgt, input bit stall,
                       input bit gnt, input bit redir_on_busy);
      bit rv, do_redir;
      logic [31:0] e, al;
      @(negedge clk);
      cyc++;
      s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid;
      s_pc = o_pc; s_instr = o_instr; s_plus4 = o_pc_plus4; s_drain = o_fsm_drain;
      if (chk_valid_low) begin
         n_vec++;
         if (s_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_valid: o_valid=%0b required 0", s_valid);
         end
         chk_valid_low = 0;
      end
      rv = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
      do_redir = redir || (redir_on_busy && rv && s_req && gnt);
      i_imem_gnt = gnt; i_stall = stall; i_redirect = do_redir; i_redirect_pc = tgt;
      i_imem_rvalid = rv;
      if (rv) begin
         i_imem_rdata = mem_word(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end else begin
         i_imem_rdata = $urandom;
      end
      if (s_req) begin
         n_vec++;
         if (s_addr !== exp_fetch) begin
            n_err++; $display("FAIL fetch_addr: got %h required %h", s_addr, exp_fetch);
         end
      end
      if (s_req && gnt) begin
         mem_addr_q.push_back(s_addr);
         mem_due_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
         exp_fetch += 4;
      end
      if (s_valid && !stall) begin
         e = exp_q.pop_front();
         n_vec += 3;
         if (s_pc !== e) begin
            n_err++; $display("FAIL decode_pc: got %h required %h", s_pc, e);
         end
         if (s_instr !== mem_word(e)) begin
            n_err++; $display("FAIL decode_instr: got %h required %h (pc %h)", s_instr, mem_word(e), e);
         end
         if (s_plus4 !== e + 32'd4) begin
            n_err++; $display("FAIL decode_pc_plus4: got %h required %h", s_plus4, e + 32'd4);
         end
         exp_q.push_back(e + 32'd4);
      end
      if (do_redir) begin
         al = {tgt[31:2], 2'b00};
         exp_fetch = al;
         exp_q.delete();
         exp_q.push_back(al);
         chk_valid_low = 1;
         redir_fired = 1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_redirect = 1'b0; i_stall = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      mem_addr_q.delete(); mem_due_q.delete();
      exp_q.delete(); exp_q.push_back('0);
      exp_fetch = '0;
      chk_valid_low = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_vec += 7;
      if (o_imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b required 0", o_imem_req); end
      if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", o_valid); end
      if (o_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h required 0", o_instr); end
      if (o_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h required 0", o_pc); end
      if (o_imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h required 0", o_imem_addr); end
      if (o_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus4: got %h required 4", o_pc_plus4); end
      if (o_fsm_drain !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b required FETCH", o_fsm_drain); end
   endtask

   task automatic test_straight_line();
      int first_valid = -1;
      int n_acc = 0;
      logic [31:0] acc_pc[3];
      int acc_step[3];
      lat_min = 1; lat_max = 1;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         step(0, '0, 0, 1, 0);
         if (k == 1) begin
            n_vec++;
            if (s_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b required 1", s_req); end
         end
         if (s_valid && first_valid < 0) first_valid = k;
         if (s_valid && n_acc < 3) begin acc_pc[n_acc] = s_pc; acc_step[n_acc] = k; n_acc++; end
      end
      n_vec += 5;
      if (first_valid != 3) begin n_err++; $display("FAIL first_valid_cycle: got %0d required 3", first_valid); end
      if (acc_pc[0] !== 32'h0) begin n_err++; $display("FAIL line_pc0: got %h required 0", acc_pc[0]); end
      if (acc_pc[1] !== 32'h4) begin n_err++; $display("FAIL line_pc1: got %h required 4", acc_pc[1]); end
      if (acc_pc[2] !== 32'h8) begin n_err++; $display("FAIL line_pc2: got %h required 8", acc_pc[2]); end
      if (acc_step[1] != acc_step[0] + 1) begin
         n_err++; $display("FAIL line_back_to_back: gap %0d required 1", acc_step[1] - acc_step[0]);
      end
   endtask

   task automatic test_stall();
      logic [31:0] held_pc, held_instr;
      int n_acc = 0;
      lat_min = 1; lat_max = 1;
      for (int i = 1; i <= 8; i++) begin
         step(0, '0, 1, 1, 0);
         if (i == 4) begin
            held_pc = s_pc; held_instr = s_instr;
            n_vec++;
            if (s_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b required 1", s_valid); end
         end
         if (i > 4) begin
            n_vec += 2;
            if (s_pc !== held_pc) begin n_err++; $display("FAIL stall_pc_hold: got %h required %h", s_pc, held_pc); end
            if (s_instr !== held_instr) begin n_err++; $display("FAIL stall_instr_hold: got %h required %h", s_instr, held_instr); end
         end
         if (i == 8) begin
            n_vec++;
            if (s_req !== 1'b0) begin n_err++; $display("FAIL stall_full_req: got %b required 0", s_req); end
         end
      end
      for (int i = 0; i < 10; i++) begin
         step(0, '0, 0, 1, 0);
         if (s_valid) n_acc++;
      end
      n_vec++;
      if (n_acc < 4) begin n_err++; $display("FAIL stall_release_drain: got %0d entries required >=4", n_acc); end
   endtask

   task automatic test_redirect_drain();
      bit found = 0;
      lat_min = 6; lat_max = 6;
      for (int i = 0; i < 40 && !found; i++) begin
         step(0, '0, 0, 1, 0);
         if (mem_addr_q.size() == 2 && mem_due_q[0] > cyc + 1) found = 1;
      end
      n_vec++;
      if (!found) begin n_err++; $display("FAIL drain_setup: got 0 required 2 outstanding"); end
      step(1, 32'h100, 0, 0, 0);
      step(0, '0, 0, 1, 0);
      n_vec += 2;
      if (s_req !== 1'b0) begin n_err++; $display("FAIL drain_req: got %b required 0", s_req); end
      if (s_drain !== 1'b1) begin n_err++; $display("FAIL drain_state: got %b required DRAIN", s_drain); end
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(0, '0, 0, 1, 0);
         if (s_req) found = 1;
      end
      n_vec++;
      if (!found || s_addr !== 32'h100) begin n_err++; $display("FAIL drain_next_addr: got %h required 00000100", s_addr); end
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(0, '0, 0, 1, 0);
         if (s_valid) found = 1;
      end
      n_vec++;
      if (!found || s_pc !== 32'h100) begin n_err++; $display("FAIL drain_first_pc: got %h required 00000100", s_pc); end
   endtask

   task automatic test_redirect_coincident();
      bit found = 0;
      lat_min = 1; lat_max = 2;
      redir_fired = 0;
      for (int i = 0; i < 40 && !redir_fired; i++) step(0, 32'h200, 0, 1, 1);
      n_vec++;
      if (!redir_fired) begin n_err++; $display("FAIL coincident_setup: got 0 required 1 redirect"); end
      for (int i = 0; i < 40 && !found; i++) begin
         step(0, '0, 0, 1, 0);
         if (s_valid) found = 1;
      end
      n_vec++;
      if (!found || s_pc !== 32'h200) begin n_err++; $display("FAIL coincident_first_pc: got %h required 00000200", s_pc); end
   endtask

   task automatic test_redirect_align_wrap();
      logic [31:0] ra[2], vp[2], vp4[2];
      int nr, nv;
      lat_min = 1; lat_max = 1;
      step(1, 32'h1003, 0, 1, 0);
      nr = 0; nv = 0;
      for (int i = 0; i < 30 && (nr < 1 || nv < 1); i++) begin
         step(0, '0, 0, 1, 0);
         if (s_req && nr < 1) begin ra[nr] = s_addr; nr++; end
         if (s_valid && nv < 1) begin vp[nv] = s_pc; nv++; end
      end
      n_vec += 2;
      if (nr < 1 || ra[0] !== 32'h1000) begin n_err++; $display("FAIL align_addr: got %h required 00001000", ra[0]); end
      if (nv < 1 || vp[0] !== 32'h1000) begin n_err++; $display("FAIL align_pc: got %h required 00001000", vp[0]); end
      step(1, 32'hFFFF_FFFC, 0, 1, 0);
      nr = 0; nv = 0;
      for (int i = 0; i < 30 && (nr < 2 || nv < 2); i++) begin
         step(0, '0, 0, 1, 0);
         if (s_req && nr < 2) begin ra[nr] = s_addr; nr++; end
         if (s_valid && nv < 2) begin vp[nv] = s_pc; vp4[nv] = s_plus4; nv++; end
      end
      n_vec += 5;
      if (nr < 2 || ra[0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr0: got %h required fffffffc", ra[0]); end
      if (nr < 2 || ra[1] !== 32'h0) begin n_err++; $display("FAIL wrap_addr1: got %h required 0", ra[1]); end
      if (nv < 2 || vp[0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc0: got %h required fffffffc", vp[0]); end
      if (nv < 2 || vp4[0] !== 32'h0) begin n_err++; $display("FAIL wrap_pc_plus4: got %h required 0", vp4[0]); end
      if (nv < 2 || vp[1] !== 32'h0) begin n_err++; $display("FAIL wrap_pc1: got %h required 0", vp[1]); end
   endtask

   task automatic test_grant_withheld_and_reset();
      bit found = 0;
      logic [31:0] addr0;
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, '0, 0, 0, 0);
         if (s_req) found = 1;
      end
      addr0 = s_addr;
      n_vec++;
      if (!found) begin n_err++; $display("FAIL nogrant_setup: got 0 required 1 request"); end
      for (int i = 0; i < 5; i++) begin
         step(0, '0, 0, 0, 0);
         n_vec += 2;
         if (s_req !== 1'b1) begin n_err++; $display("FAIL nogrant_req_hold: got %b required 1", s_req); end
         if (s_addr !== addr0) begin n_err++; $display("FAIL nogrant_addr_hold: got %h required %h", s_addr, addr0); end
      end
      for (int i = 0; i < 6; i++) step(0, '0, 1, 1, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec += 6;
      if (o_imem_req !== 1'b0) begin n_err++; $display("FAIL async_req: got %b required 0", o_imem_req); end
      if (o_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b required 0", o_valid); end
      if (o_instr !== 32'h0) begin n_err++; $display("FAIL async_instr: got %h required 0", o_instr); end
      if (o_pc !== 32'h0) begin n_err++; $display("FAIL async_pc: got %h required 0", o_pc); end
      if (o_imem_addr !== 32'h0) begin n_err++; $display("FAIL async_addr: got %h required 0", o_imem_addr); end
      if (o_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL async_pc_plus4: got %h required 4", o_pc_plus4); end
      do_reset();
      for (int i = 0; i < 12; i++) step(0, '0, 0, 1, 0);
   endtask

   task automatic test_random();
      int r;
      logic [31:0] tgt;
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         tgt = $urandom;
         if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         step(r < 3, tgt, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 75, (r >= 3) && (r < 5));
      end
      for (int i = 0; i < 20; i++) step(0, '0, 0, 1, 0);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_straight_line();
      test_stall();
      test_redirect_drain();
      test_redirect_coincident();
      test_redirect_align_wrap();
      test_grant_withheld_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
